// File: rtl/running_adder.sv
`default_nettype none
// ============================================================================
// Module   : running_adder
// Purpose  : Two-stage pipelined add/subtract unit with valid/ready handshake.
//            Stage 1 forms the raw WIDTH+1-bit sum or difference (carry or
//            borrow in the top bit). Stage 2 applies the per-transaction mode
//            correction (wrap, modulo LIMIT, saturate, accumulate) and drives
//            the registered outputs.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            in_valid / in_ready  - operand handshake (a, b, sub, mode)
//            out_valid / out_ready- result handshake (sum, carry, ovf, err)
//            a, b                 - unsigned operands (b unused in mode 11)
//            sub                  - 0 add, 1 subtract
//            mode                 - 00 wrap, 01 modulo, 10 saturate, 11 acc
//            sum                  - corrected result
//            carry                - raw carry (add) / borrow (sub)
//            ovf                  - modulo correction or clamp applied
//            err                  - operand out of range in modulo mode
// Revision : 1.0 - initial release
// ============================================================================
module running_adder #(
  parameter int WIDTH = 10,
  parameter int LIMIT = 640
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  // LIMIT may equal 2^WIDTH, so the bounds are held one bit wider.
  localparam logic [WIDTH:0] LIM    = (WIDTH+1)'(LIMIT);
  localparam logic [WIDTH:0] LIM_M1 = (WIDTH+1)'(LIMIT - 1);

  localparam logic [1:0] MODE_WRAP = 2'b00;
  localparam logic [1:0] MODE_MOD  = 2'b01;
  localparam logic [1:0] MODE_SAT  = 2'b10;
  localparam logic [1:0] MODE_ACC  = 2'b11;

  // Whole pipeline advances together; a stalled output freezes both stages.
  logic adv;
  logic take;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign take     = in_valid && adv;

  // --------------------------------------------------------------------------
  // Stage 1: raw arithmetic
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   opx;
  logic [WIDTH:0]   opy;
  logic [WIDTH:0]   raw_d;
  logic             range_err_d;

  always_comb begin
    opx = {1'b0, a};
    opy = {1'b0, b};
    // Accumulate mode operates on acc and a; b is ignored.
    if (mode == MODE_ACC) begin
      opx = {1'b0, acc};
      opy = {1'b0, a};
    end
    // Zero-extended WIDTH+1-bit subtraction leaves the borrow in the top bit.
    raw_d       = sub ? (opx - opy) : (opx + opy);
    range_err_d = (mode == MODE_MOD) && (({1'b0, a} >= LIM) || ({1'b0, b} >= LIM));
  end

  logic             v1;
  logic [WIDTH:0]   raw1;
  logic [1:0]       mode1;
  logic             sub1;
  logic             err1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      raw1  <= '0;
      mode1 <= 2'b00;
      sub1  <= 1'b0;
      err1  <= 1'b0;
      acc   <= '0;
    end else begin
      if (adv) begin
        v1 <= in_valid;
      end
      if (take) begin
        raw1  <= raw_d;
        mode1 <= mode;
        sub1  <= sub;
        err1  <= range_err_d;
        // acc is updated at acceptance so a following accumulate
        // transaction in the very next cycle already sees the new value.
        if (mode == MODE_ACC) begin
          acc <= raw_d[WIDTH-1:0];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: mode correction
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   minus_lim;
  logic [WIDTH-1:0] sum_d;
  logic             ovf_d;
  logic             err_d;

  assign minus_lim = raw1 - LIM;

  always_comb begin
    sum_d = raw1[WIDTH-1:0];
    ovf_d = 1'b0;
    err_d = 1'b0;
    case (mode1)
      MODE_MOD: begin
        if (err1) begin
          sum_d = '0;
          err_d = 1'b1;
        end else if (sub1) begin
          // Negative difference: add LIMIT back. The true result lies in
          // [0, LIMIT), so working modulo 2^WIDTH is exact (and covers
          // LIMIT == 2^WIDTH, where the low bits of LIM are zero).
          if (raw1[WIDTH]) begin
            sum_d = raw1[WIDTH-1:0] + LIM[WIDTH-1:0];
            ovf_d = 1'b1;
          end
        end else if (raw1 >= LIM) begin
          sum_d = minus_lim[WIDTH-1:0];
          ovf_d = 1'b1;
        end
      end
      MODE_SAT: begin
        if (sub1) begin
          if (raw1[WIDTH]) begin
            sum_d = '0;
            ovf_d = 1'b1;
          end
        end else if (raw1 > LIM_M1) begin
          sum_d = LIM_M1[WIDTH-1:0];
          ovf_d = 1'b1;
        end
      end
      default: begin
        // Wrap and accumulate deliver the raw low bits unchanged.
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else if (adv) begin
      out_valid <= v1;
      // Bubbles leave the last result on the pins rather than loading junk.
      if (v1) begin
        sum   <= sum_d;
        carry <= raw1[WIDTH];
        ovf   <= ovf_d;
        err   <= err_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_running_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_running_adder
// Purpose  : Self-checking bench for running_adder (WIDTH=10, LIMIT=640).
//            Expected results come from a behavioural model evaluated when a
//            transaction is accepted and are queued; the monitor pops and
//            compares them when the DUT delivers a result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_running_adder;

  localparam int W   = 10;
  localparam int L   = 640;
  localparam int MOD = 1 << W;

  typedef struct {
    int sum;
    int carry;
    int ovf;
    int err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         carry;
  logic         ovf;
  logic         err;

  running_adder #(.WIDTH(W), .LIMIT(L)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  int   m_acc    = 0;
  bit   rnd_ready = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int wrap(input int v);
    return (v + 2 * MOD) % MOD;
  endfunction

  // Independent behavioural model; updates the model accumulator in mode 3.
  function automatic exp_t model(input int av, input int bv, input bit s, input int m);
    exp_t e;
    int x, y, r;
    x = (m == 3) ? m_acc : av;
    y = (m == 3) ? av : bv;
    r = s ? x - y : x + y;
    e.carry = s ? int'(x < y) : int'(r >= MOD);
    e.ovf = 0;
    e.err = 0;
    e.sum = wrap(r);
    if (m == 1) begin
      if (av >= L || bv >= L) begin
        e.sum = 0;
        e.err = 1;
      end else if (s && r < 0) begin
        e.sum = r + L;
        e.ovf = 1;
      end else if (!s && r >= L) begin
        e.sum = r - L;
        e.ovf = 1;
      end
    end else if (m == 2) begin
      if (s && r < 0) begin
        e.sum = 0;
        e.ovf = 1;
      end else if (!s && r > L - 1) begin
        e.sum = L - 1;
        e.ovf = 1;
      end
    end else if (m == 3) begin
      m_acc = wrap(r);
    end
    return e;
  endfunction

  // Offer one transaction; returns #1 after the accepting edge.
  task automatic send(input int av, input int bv, input bit s, input int m);
    int n;
    bit done;
    a = av[W-1:0];
    b = bv[W-1:0];
    sub = s;
    mode = m[1:0];
    in_valid = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done && n < 60) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(av, bv, s, m));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) check("send_timeout", 0, 1);
    in_valid = 1'b0;
    // Scramble the pins so a late-captured mode/sub would corrupt results.
    a = W'($urandom);
    b = W'($urandom);
    sub = 1'($urandom);
    mode = 2'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", q.size(), 0);
  endtask

  // Randomised backpressure, changed away from the edge the sender samples.
  always @(posedge clk) begin
    if (rnd_ready) begin
      #2;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Output monitor: compare on transfer, check hold stability while stalled.
  bit           stall_prev = 1'b0;
  logic [W-1:0] h_sum;
  logic         h_carry, h_ovf, h_err;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (stall_prev) begin
        check("hold_sum", int'(sum), int'(h_sum));
        check("hold_flags", int'({carry, ovf, err}), int'({h_carry, h_ovf, h_err}));
      end
      if (out_ready) begin
        stall_prev = 1'b0;
        if (q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = q.pop_front();
          check("sum", int'(sum), e.sum);
          check("carry", int'(carry), e.carry);
          check("ovf", int'(ovf), e.ovf);
          check("err", int'(err), e.err);
        end
      end else begin
        check("in_ready_stall", int'(in_ready), 0);
        stall_prev = 1'b1;
        h_sum   = sum;
        h_carry = carry;
        h_ovf   = ovf;
        h_err   = err;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_outputs", int'({sum, carry, ovf, err}), 0);
    rst = 1'b0;
    check("rst_in_ready", int'(in_ready), 1);

    // Mode 00 wrap add with latency check
    send(1000, 30, 1'b0, 0);
    check("lat_cycle1", int'(out_valid), 0);
    @(posedge clk);
    #1;
    check("lat_cycle2", int'(out_valid), 1);
    drain();

    // Wrap subtract, modulo, saturate vectors
    send(5, 9, 1'b1, 0);
    send(630, 15, 1'b0, 1);
    send(3, 10, 1'b1, 1);
    send(700, 1, 1'b0, 1);
    send(639, 639, 1'b1, 1);
    send(600, 100, 1'b0, 2);
    send(5, 9, 1'b1, 2);
    send(100, 200, 1'b0, 2);
    send(1023, 1023, 1'b0, 2);
    drain();

    // Accumulate: 500, 1000, 476 (carry), then 476-480 = 1020 (borrow)
    send(500, 0, 1'b0, 3);
    send(500, 0, 1'b0, 3);
    send(500, 0, 1'b0, 3);
    send(480, 0, 1'b1, 3);
    drain();

    // Four back-to-back adds with a 3-cycle stall mid-stream
    fork
      begin
        send(1, 2, 1'b0, 0);
        send(1000, 100, 1'b0, 0);
        send(300, 400, 1'b0, 0);
        send(7, 8, 1'b0, 0);
      end
      begin
        repeat (2) @(posedge clk);
        #2 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    drain();

    // Random mix under random backpressure, with interleaved accumulates
    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)),
           1'($urandom), int'($urandom_range(0, 3)));
    end
    drain();
    rnd_ready = 1'b0;
    @(posedge clk);
    #3 out_ready = 1'b1;

    // Bring acc to 1000, then reset with two transactions in flight
    send(wrap(1000 - m_acc), 0, 1'b0, 3);
    drain();
    out_ready = 1'b0;
    send(11, 22, 1'b0, 0);
    send(33, 44, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    m_acc = 0;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_outputs", int'({sum, carry, ovf, err}), 0);
    rst = 1'b0;
    check("midrst_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    send(7, 0, 1'b0, 3);
    drain();
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
